decode_trace_queue: RTL

Elastic buffer between the instruction decoder and the instruction print/trace stage.
- Accepts one decoded fat_instruction_t per cycle, tagged with its RIP and byte length.
- Stamps each entry with a sequence number and a control-flow discontinuity flag.
- Hands entries in order to the printer over a valid/ready handshake, isolating decoder throughput from trace-consumer stalls.

---
 rtl/decode_trace_queue_pkg.sv | 28 ++
 rtl/decode_trace_queue_fifo.sv | 57 +++++
 rtl/decode_trace_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/decode_trace_queue_pkg.sv
// Shared decoder types: the decoded instruction record and the trace entry
// that carries it through the decode-to-trace elastic buffer.
package DecoderTypes;

  localparam int MAX_INSTR_LEN = 15;
  localparam int MAX_SEQ_W     = 32;

  typedef struct packed {
    logic [7:0]  prefix;
    logic [15:0] opcode;
    logic [7:0]  modrm;
  } fat_instruction_t;

  // seq is stored at the maximum width; narrower counters are zero-extended.
  typedef struct packed {
    fat_instruction_t       instr;
    logic [63:0]            rip;
    logic [3:0]             len;
    logic [MAX_SEQ_W-1:0]   seq;
    logic                   discont;
    logic                   bad_len;
  } trace_entry_t;

  function automatic logic [63:0] next_rip(input logic [63:0] rip, input logic [3:0] len);
    return rip + 64'(len);
  endfunction

endpackage

// File: rtl/decode_trace_queue_fifo.sv
// Synchronous FIFO of trace entries with wrap-bit pointers and a flush that
// takes priority over any same-cycle push or pop.
module trace_fifo
  import DecoderTypes::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  trace_entry_t             i_data,
  output trace_entry_t             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  trace_entry_t r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty slots are never observed
  // because the head output is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/decode_trace_queue.sv
// Decode-to-trace elastic buffer: stamps each decoded instruction with a
// sequence number and a control-flow discontinuity flag, then queues it.
module decode_trace_queue
  import DecoderTypes::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  fat_instruction_t         in_instr,
  input  logic [63:0]              in_rip,
  input  logic [3:0]               in_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output fat_instruction_t         out_instr,
  output logic [63:0]              out_rip,
  output logic [3:0]               out_len,
  output logic [SEQ_W-1:0]         out_seq,
  output logic                     out_discont,
  output logic                     out_bad_len,
  output logic [$clog2(DEPTH):0]   count
);

  logic [SEQ_W-1:0] r_seq_cnt;
  logic [63:0]      r_exp_rip;
  logic             r_exp_valid;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  trace_entry_t     w_entry;
  trace_entry_t     w_head;

  // Acceptance never looks at out_ready, so a full queue stalls even on a pop.
  assign in_ready  = !w_full && !flush;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;

  assign w_entry = '{
    instr:   in_instr,
    rip:     in_rip,
    len:     in_len,
    seq:     MAX_SEQ_W'(r_seq_cnt),
    discont: r_exp_valid && (in_rip != r_exp_rip),
    bad_len: (in_len == 4'd0)
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_cnt   <= '0;
      r_exp_rip   <= '0;
      r_exp_valid <= 1'b0;
    end else begin
      if (w_push) r_seq_cnt <= r_seq_cnt + 1'b1;
      // The sequence counter survives a flush; only fall-through tracking restarts.
      if (flush) begin
        r_exp_valid <= 1'b0;
      end else if (w_push) begin
        r_exp_rip   <= next_rip(in_rip, in_len);
        r_exp_valid <= 1'b1;
      end
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (out_ready),
    .i_flush (flush),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign out_instr   = w_head.instr;
  assign out_rip     = w_head.rip;
  assign out_len     = w_head.len;
  assign out_seq     = w_head.seq[SEQ_W-1:0];
  assign out_discont = w_head.discont;
  assign out_bad_len = w_head.bad_len;

endmodule
